aip_start_ctrl: RTL and testbench

AIP_START_CTRL -- requirements
Module: aip_start_ctrl

---
 rtl/aip_pkg.sv | 28 ++
 rtl/aip_start_ctrl.sv | 120 ++++++++++++
 tb/tb_aip_start_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aip_pkg.sv
// Shared aip definitions: controller state encoding and status/interrupt bit map.
package aip_pkg;

  localparam int unsigned FLAG_W = 8;

  // statusFlags bit indices
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_TIMEOUT = 1;
  localparam int unsigned STAT_REJECT  = 2;

  // intFlags bit indices
  localparam int unsigned INT_DONE    = 0;
  localparam int unsigned INT_TIMEOUT = 1;
  localparam int unsigned INT_ABORT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } aip_state_e;

  // A job is in flight from launch until it leaves RUN.
  function automatic logic is_busy_state(input aip_state_e s);
    return (s == ST_LAUNCH) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/aip_start_ctrl.sv
// Start/abort/timeout controller for an accelerator core; all outputs registered.
module aip_start_ctrl
  import aip_pkg::*;
#(
  parameter int unsigned CNTWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startReq,
  input  logic                abortReq,
  input  logic [CNTWIDTH-1:0] timeoutCfg,
  input  logic                coreDone,
  output logic                coreStart,
  output logic                coreAbort,
  output logic [FLAG_W-1:0]   statusFlags,
  output logic [FLAG_W-1:0]   intFlags,
  output logic [CNTWIDTH-1:0] runCycles
);

  aip_state_e          state_q, state_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic [CNTWIDTH-1:0] tmo_q, tmo_d;
  logic [CNTWIDTH-1:0] run_cycles_q, run_cycles_d;
  logic                core_start_q, core_start_d;
  logic                core_abort_q, core_abort_d;
  logic [FLAG_W-1:0]   status_q, status_d;
  logic [FLAG_W-1:0]   int_q, int_d;

  // Next state, counter, latches and output pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    run_cycles_d = run_cycles_q;
    core_abort_d = 1'b0;
    status_d     = status_q;
    int_d        = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (startReq) begin
          state_d                = ST_LAUNCH;
          status_d[STAT_TIMEOUT] = 1'b0;
          status_d[STAT_REJECT]  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (startReq) status_d[STAT_REJECT] = 1'b1;
        tmo_d = timeoutCfg;
        if (abortReq) begin
          state_d            = ST_IDLE;
          core_abort_d       = 1'b1;
          int_d[INT_ABORT]   = 1'b1;
          run_cycles_d       = '0;
        end else begin
          state_d = ST_RUN;
          cnt_d   = CNTWIDTH'(1);
        end
      end
      ST_RUN: begin
        if (startReq) status_d[STAT_REJECT] = 1'b1;
        if (coreDone) begin
          state_d          = ST_DONE;
          run_cycles_d     = cnt_q;
          int_d[INT_DONE]  = 1'b1;
        end else if (abortReq) begin
          state_d          = ST_IDLE;
          run_cycles_d     = cnt_q;
          core_abort_d     = 1'b1;
          int_d[INT_ABORT] = 1'b1;
        end else if ((tmo_q != '0) && (cnt_q == tmo_q)) begin
          state_d                = ST_IDLE;
          run_cycles_d           = cnt_q;
          core_abort_d           = 1'b1;
          int_d[INT_TIMEOUT]     = 1'b1;
          status_d[STAT_TIMEOUT] = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNTWIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // LAUNCH is entered only from IDLE/DONE, so this is a single-cycle pulse.
    core_start_d        = (state_d == ST_LAUNCH);
    status_d[STAT_BUSY] = is_busy_state(state_d);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      run_cycles_q <= '0;
      core_start_q <= 1'b0;
      core_abort_q <= 1'b0;
      status_q     <= '0;
      int_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      run_cycles_q <= run_cycles_d;
      core_start_q <= core_start_d;
      core_abort_q <= core_abort_d;
      status_q     <= status_d;
      int_q        <= int_d;
    end
  end

  assign coreStart   = core_start_q;
  assign coreAbort   = core_abort_q;
  assign statusFlags = status_q;
  assign intFlags    = int_q;
  assign runCycles   = run_cycles_q;

endmodule

// File: tb/tb_aip_start_ctrl.sv
// Self-checking bench for aip_start_ctrl: job-level model plus directed literal checks.
module tb_aip_start_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startReq = 1'b0;
  logic          abortReq = 1'b0;
  logic [CW-1:0] timeoutCfg = '0;
  logic          coreDone = 1'b0;
  logic          coreStart, coreAbort;
  logic [7:0]    statusFlags, intFlags;
  logic [CW-1:0] runCycles;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  aip_start_ctrl #(.CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .startReq(startReq), .abortReq(abortReq),
    .timeoutCfg(timeoutCfg), .coreDone(coreDone), .coreStart(coreStart),
    .coreAbort(coreAbort), .statusFlags(statusFlags), .intFlags(intFlags),
    .runCycles(runCycles)
  );

  always #5 clk = ~clk;

  // Job-level model: a job is "active" from the accepted start until it ends;
  // "first" marks its launch cycle; elapsed counts run cycles of the job.
  logic        m_active = 1'b0, m_first = 1'b0, m_tmo_flag = 1'b0, m_rej_flag = 1'b0;
  int unsigned m_elapsed = 0, m_limit = 0, m_last = 0;
  logic        e_start = 1'b0, e_abort = 1'b0;
  logic [7:0]  e_status = '0, e_int = '0;
  int unsigned e_rc = 0;

  always @(posedge clk) begin : model
    logic act, first, tf, rf, st, ab;
    int unsigned el, lim, last;
    logic [7:0] ints;
    act = m_active; first = m_first; tf = m_tmo_flag; rf = m_rej_flag;
    el = m_elapsed; lim = m_limit; last = m_last;
    st = 1'b0; ab = 1'b0; ints = '0;
    if (rst) begin
      act = 0; first = 0; tf = 0; rf = 0; el = 0; lim = 0; last = 0;
    end else if (!act) begin
      if (startReq) begin
        act = 1; first = 1; tf = 0; rf = 0; st = 1;
      end
    end else begin
      if (startReq) rf = 1;
      if (first) begin
        lim = timeoutCfg;
        if (abortReq) begin
          act = 0; ab = 1; ints[2] = 1; last = 0;
        end else begin
          first = 0; el = 1;
        end
      end else if (coreDone) begin
        act = 0; ints[0] = 1; last = el;
      end else if (abortReq) begin
        act = 0; ab = 1; ints[2] = 1; last = el;
      end else if (lim != 0 && el == lim) begin
        act = 0; ab = 1; ints[1] = 1; tf = 1; last = el;
      end else if (el < CMAX) begin
        el = el + 1;
      end
    end
    m_active <= act; m_first <= first; m_tmo_flag <= tf; m_rej_flag <= rf;
    m_elapsed <= el; m_limit <= lim; m_last <= last;
    e_start  <= st;
    e_abort  <= ab;
    e_int    <= ints;
    e_status <= {5'b0, rf, tf, act};
    e_rc     <= last;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_coreStart",   coreStart,   e_start);
      check("m_coreAbort",   coreAbort,   e_abort);
      check("m_statusFlags", statusFlags, e_status);
      check("m_intFlags",    intFlags,    e_int);
      check("m_runCycles",   runCycles,   e_rc);
    end
  end

  // Advance to just after the next rising edge, i.e. the start of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    mid();
    check("rst_status", statusFlags, 8'h00);
    check("rst_int", intFlags, 8'h00);
    check("rst_rc", runCycles, 0);

    // Done path: start c0, done c6.
    tick(); startReq = 1;                 // c0
    tick(); startReq = 0;                 // c1
    mid(); check("s1_coreStart_c1", coreStart, 1); check("s1_busy_c1", statusFlags, 8'h01);
    tick(); mid(); check("s1_noStart_c2", coreStart, 0);
    tick(); tick(); tick();               // c5
    tick(); coreDone = 1;                 // c6
    mid(); check("s1_busy_c6", statusFlags, 8'h01);
    tick(); coreDone = 0;                 // c7
    mid(); check("s1_int_c7", intFlags, 8'h01); check("s1_rc", runCycles, 5);
    check("s1_busy_c7", statusFlags, 8'h00);
    tick(); mid(); check("s1_int_c8", intFlags, 8'h00);

    // Timeout 4; config changed after launch must not matter.
    timeoutCfg = 4;
    tick(); startReq = 1;                 // c0
    tick(); startReq = 0;                 // c1 launch
    tick(); timeoutCfg = 0;               // c2 R1
    tick(); tick(); tick();               // c5 R4
    mid(); check("s2_busy_R4", statusFlags, 8'h01); check("s2_noAbort_R4", coreAbort, 0);
    tick(); mid();                        // c6
    check("s2_int", intFlags, 8'h02); check("s2_abort", coreAbort, 1);
    check("s2_status", statusFlags, 8'h02); check("s2_rc", runCycles, 4);

    // Abort in third run cycle; new start clears timeout sticky.
    tick(); startReq = 1;                 // c0
    tick(); startReq = 0;                 // c1
    mid(); check("s3_status_c1", statusFlags, 8'h01);
    tick(); tick();                       // c3 R2
    tick(); abortReq = 1;                 // c4 R3
    tick(); abortReq = 0;                 // c5
    mid(); check("s3_int", intFlags, 8'h04); check("s3_abort", coreAbort, 1);
    check("s3_rc", runCycles, 3); check("s3_busy", statusFlags[0], 0);

    // Done and abort together: done wins. Then abort in DONE ignored, start from DONE.
    tick(); startReq = 1;
    tick(); startReq = 0;                 // launch
    tick(); coreDone = 1; abortReq = 1;   // R1
    tick(); coreDone = 0; abortReq = 1; startReq = 1;  // DONE
    mid(); check("s4_int", intFlags, 8'h01); check("s4_noAbort", coreAbort, 0);
    check("s4_rc", runCycles, 1);
    tick(); abortReq = 0; startReq = 0;   // launch from DONE
    mid(); check("s4_restart", coreStart, 1); check("s4_abortIgnored", coreAbort, 0);
    // Start during run is rejected.
    tick();                               // R1
    tick(); startReq = 1;                 // R2
    tick(); startReq = 0; coreDone = 1;   // R3
    mid(); check("s5_rej", statusFlags, 8'h05); check("s5_noStart", coreStart, 0);
    tick(); coreDone = 0;                 // DONE
    mid(); check("s5_rejSticky", statusFlags, 8'h04); check("s5_rc", runCycles, 3);
    tick(); startReq = 1;                 // idle, start
    tick(); startReq = 0;                 // launch
    mid(); check("s5_rejCleared", statusFlags, 8'h01); check("s5_start", coreStart, 1);

    // Reset mid-run.
    tick(); tick(); rst = 1;              // R2
    tick(); rst = 0;
    mid(); check("s6_status", statusFlags, 0); check("s6_int", intFlags, 0);
    check("s6_abort", coreAbort, 0); check("s6_rc", runCycles, 0);
    tick(); mid(); check("s6_noPulse", intFlags, 0); check("s6_noStart", coreStart, 0);

    // coreDone in IDLE/LAUNCH ignored; counter saturation over 20 run cycles.
    coreDone = 1; tick(); coreDone = 0;
    tick(); startReq = 1;
    tick(); startReq = 0; coreDone = 1;   // launch
    tick(); coreDone = 0;                 // R1
    mid(); check("s7_busy", statusFlags, 8'h01); check("s7_noDone", intFlags, 0);
    for (int i = 0; i < 19; i++) tick();  // R20
    coreDone = 1;
    tick(); coreDone = 0;
    mid(); check("s7_rc_sat", runCycles, CMAX);

    // Timeout at all-ones limit.
    timeoutCfg = CW'(CMAX);
    tick(); startReq = 1;
    tick(); startReq = 0;
    for (int i = 0; i < 15; i++) tick();  // R15
    tick();
    mid(); check("s8_int", intFlags, 8'h02); check("s8_rc", runCycles, CMAX);

    // Done on the timeout cycle: done wins.
    timeoutCfg = 3;
    tick(); startReq = 1;
    tick(); startReq = 0;
    tick(); tick(); tick(); coreDone = 1; // R3
    tick(); coreDone = 0;
    mid(); check("s9_int", intFlags, 8'h01); check("s9_noAbort", coreAbort, 0);
    check("s9_status", statusFlags, 8'h00);

    // Abort during launch: runCycles 0.
    timeoutCfg = 0;
    tick(); startReq = 1;
    tick(); startReq = 0; abortReq = 1;   // launch
    tick(); abortReq = 0;
    mid(); check("s10_int", intFlags, 8'h04); check("s10_abort", coreAbort, 1);
    check("s10_rc", runCycles, 0); check("s10_busy", statusFlags, 8'h00);

    tick(); tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
